priority_arbiter: RTL
=====================

PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001: Parameter N, default 8; number of request channels, N >= 2.
REQ-002: Parameter W, default $clog2(N); grant index width.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: en  input  1  arbitration enable; sampled only when a new grant may be loaded.
REQ-006: mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin; sampled only at arbitration.
REQ-007: req  input  N  request vector, bit k = channel k requesting.
REQ-008: gnt_ready  input  1  consumer accepts current grant when gnt_valid=1 and gnt_ready=1.
REQ-009: gnt_valid  output  1  registered; a grant is presented.
REQ-010: gnt_idx  output  W  registered; binary index of the granted channel.
REQ-011: gnt_onehot  output  N  registered; one-hot of gnt_idx, all zero when gnt_valid=0.
REQ-012: last_idx  output  W  registered; index of the most recently accepted grant (round-robin pointer).

Function
REQ-013: The block SHALL implement two states: IDLE (gnt_valid=0) and GRANT (gnt_valid=1).
REQ-014: IDLE -> GRANT when en=1 and req!=0; winner loaded on that edge, so gnt_valid rises 1 cycle after req is sampled.
REQ-015: IDLE holds with all grant outputs zero when en=0 or req=0; outputs are never high-impedance.
REQ-016: Fixed mode: winner = highest set index of req.
REQ-017: Round-robin mode: search starts at (last_idx-1) mod N, descends, and wraps from 0 to N-1; first set bit wins, so the last winner has lowest priority.
REQ-018: In GRANT with gnt_ready=0, gnt_valid, gnt_idx and gnt_onehot SHALL hold stable regardless of req, en or mode changes, including withdrawal of the granted request.
REQ-019: On handshake (gnt_valid & gnt_ready): last_idx <= gnt_idx; if en=1 and req!=0 in the same cycle, the next winner is loaded and the state remains GRANT (back-to-back, no bubble); otherwise -> IDLE.
REQ-020: Back-to-back arbitration in round-robin mode SHALL use the just-accepted gnt_idx as the pointer, not the stale last_idx.
REQ-021: Only one channel is ever granted; gnt_onehot SHALL be exactly one-hot whenever gnt_valid=1.
REQ-022: Index arithmetic is modulo N; for non-power-of-2 N, no index >= N is ever produced.

Reset
REQ-023: While rst_n=0, state=IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0, last_idx=0, asynchronously.
REQ-024: With last_idx=0 after reset, the first round-robin search starts at N-1, identical to fixed priority.
REQ-025: Reset asserted mid-GRANT SHALL drop the grant immediately with no handshake; first grant after release follows REQ-014.

Structure
REQ-026: Package priority_arbiter_pkg SHALL hold the state enum (IDLE, GRANT) and the mode constants MODE_FIXED=0, MODE_RR=1.
REQ-027: A combinational sub-module prio_pick (parameter N; inputs vector and start index; outputs found flag and index) SHALL perform the wrapped downward search; fixed mode uses start index N-1.
REQ-028: priority_arbiter SHALL contain the FSM, output registers and pointer only; no other sub-modules.

Verification (N=8)
REQ-029: Fixed: en=1, mode=0, req=8'b0010_1100, gnt_ready=1 -> next cycle gnt_valid=1, gnt_idx=5, gnt_onehot=8'b0010_0000; with req held, idx 5 every cycle.
REQ-030: Round-robin: mode=1, req=8'hFF held, gnt_ready=1 -> gnt_idx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles, no bubbles.
REQ-031: Stall: grant idx 3 presented, gnt_ready=0 for 4 cycles while req changes to 8'h80 and mode toggles -> idx 3 held stable; on ready=1, next grant idx 7.
REQ-032: Disable/empty: en=0 with req=8'hFF, or en=1 with req=0 -> gnt_valid stays 0, gnt_onehot=0 for 10 cycles.
REQ-033: Reset: rst_n pulled low mid-GRANT (idx 6, ready=0) -> gnt_valid=0 and last_idx=0 without waiting for a clock edge; after release with mode=1, req=8'h41, first grant is idx 6.
REQ-034: Wrap: mode=1, last_idx=0 after accepting idx 0, req=8'b1000_0001 -> next grant idx 7, then idx 0.

Source files
------------

// File: rtl/priority_arbiter_pkg.sv
// rtl/priority_arbiter_pkg.sv - shared types and constants for the priority arbiter
// Contents:
//   state_e    : arbiter FSM state (IDLE = no grant presented, GRANT = grant presented)
//   MODE_FIXED : mode input value selecting fixed priority (highest index wins)
//   MODE_RR    : mode input value selecting round-robin
package priority_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - combinational wrapped downward search for the first set bit
// Ports:
//   vec   [N-1:0] : candidate vector, bit k = channel k eligible
//   start [W-1:0] : index examined first; the search descends and wraps 0 -> N-1
//   found         : at least one bit of vec is set
//   idx   [W-1:0] : first set index met by the search (0 when found = 0)
module prio_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  // Position of the i-th probe: (start - i) mod N. Done in int so that
  // non-power-of-2 N wraps to N-1 rather than to 2**W-1.
  function automatic logic [W-1:0] probe(input logic [W-1:0] s, input int i);
    int p;
    p = int'(s) - i;
    if (p < 0) begin
      p = p + N;
    end
    return W'(p);
  endfunction

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && vec[probe(start, i)]) begin
        found = 1'b1;
        idx   = probe(start, i);
      end
    end
  end

endmodule

// File: rtl/priority_arbiter.sv
// rtl/priority_arbiter.sv - fixed/round-robin arbiter with a valid/ready grant output
// Ports:
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   en                    : arbitration enable, sampled when a new grant may load
//   mode                  : MODE_FIXED (highest index wins) or MODE_RR (round-robin)
//   req        [N-1:0]    : request vector
//   gnt_ready             : consumer accepts the presented grant
//   gnt_valid             : a grant is presented (registered)
//   gnt_idx    [W-1:0]    : binary index of the granted channel (registered)
//   gnt_onehot [N-1:0]    : one-hot of gnt_idx, zero when no grant (registered)
//   last_idx   [W-1:0]    : index of the most recently accepted grant (registered)
module priority_arbiter
  import priority_arbiter_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] last_idx
);

  localparam logic [W-1:0] TOP_IDX = W'(N - 1);

  state_e       state_q, state_d;
  logic [W-1:0] gnt_idx_q, gnt_idx_d;
  logic [N-1:0] gnt_onehot_q, gnt_onehot_d;
  logic [W-1:0] last_idx_q, last_idx_d;

  logic         handshake;
  logic [W-1:0] rr_ptr;
  logic [W-1:0] rr_start;
  logic [W-1:0] search_start;
  logic         pick_found;
  logic [W-1:0] pick_idx;

  assign handshake = (state_q == GRANT) && gnt_ready;

  // On a back-to-back handshake the grant being accepted this cycle is the
  // newest winner, so it must steer the search instead of the stale pointer.
  assign rr_ptr       = handshake ? gnt_idx_q : last_idx_q;
  assign rr_start     = (rr_ptr == '0) ? TOP_IDX : rr_ptr - W'(1);
  assign search_start = (mode == MODE_RR) ? rr_start : TOP_IDX;

  prio_pick #(
    .N(N),
    .W(W)
  ) u_pick (
    .vec   (req),
    .start (search_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  function automatic logic [N-1:0] to_onehot(input logic [W-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always_comb begin
    state_d      = state_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;
    last_idx_d   = last_idx_q;

    unique case (state_q)
      IDLE: begin
        if (en && pick_found) begin
          state_d      = GRANT;
          gnt_idx_d    = pick_idx;
          gnt_onehot_d = to_onehot(pick_idx);
        end else begin
          gnt_idx_d    = '0;
          gnt_onehot_d = '0;
        end
      end
      GRANT: begin
        // Without ready the grant is frozen whatever req/en/mode do.
        if (gnt_ready) begin
          last_idx_d = gnt_idx_q;
          if (en && pick_found) begin
            gnt_idx_d    = pick_idx;
            gnt_onehot_d = to_onehot(pick_idx);
          end else begin
            state_d      = IDLE;
            gnt_idx_d    = '0;
            gnt_onehot_d = '0;
          end
        end
      end
      default: begin
        state_d      = IDLE;
        gnt_idx_d    = '0;
        gnt_onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      last_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
      last_idx_q   <= last_idx_d;
    end
  end

  assign gnt_valid  = (state_q == GRANT);
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;
  assign last_idx   = last_idx_q;

endmodule
